pipe_trace_buffer: RTL and testbench
====================================

# pipe_trace_buffer

Parametrised on-chip instruction trace capture for the pipelined MIPS core. It records (PC, IR) pairs from the fetch stage into a circular buffer, stops on a PC-match or forced trigger after a programmable number of post-trigger samples, and then streams the captured window out oldest-first over a valid/ready port. It is the synthesizable successor to per-cycle PC/IR monitoring: it adds depth, trigger and readout control, and can be left in silicon.

## Interface

Parameters:
- ADDR_W, 32: PC width.
- DATA_W, 32: IR width.
- DEPTH, 8: buffer entries; power of two, ≥ 2.
- CW, $clog2(DEPTH)+1: count width (derived; not overridden).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- arm  in  1  pulse; IDLE -> ARMED.
- abort  in  1  any state -> IDLE; clears counts.
- trig_en  in  1  enables PC-match trigger.
- trig_pc  in  ADDR_W  PC match value.
- force_trig  in  1  immediate trigger while ARMED.
- post_cnt  in  CW  samples stored after the trigger sample; sampled at trigger.
- cap_valid  in  1  a new fetch is present this cycle.
- cap_pc  in  ADDR_W  fetch PC.
- cap_ir  in  DATA_W  fetched instruction.
- rd_valid  out  1  readout data valid.
- rd_ready  in  1  consumer accepts.
- rd_pc  out  ADDR_W  readout PC.
- rd_ir  out  DATA_W  readout IR.
- rd_last  out  1  final entry of the window.
- busy  out  1  high in ARMED/POST.
- done  out  1  high in READ.
- entries  out  CW  valid entries held, saturates at DEPTH.

## Operation

- States: IDLE, ARMED, POST, READ.
- IDLE: nothing is written. arm -> ARMED, with wr_ptr=0 and entries=0.
- ARMED: each cap_valid writes {cap_pc, cap_ir} at wr_ptr, wr_ptr increments modulo DEPTH, and entries increments saturating at DEPTH.
  - Trigger = force_trig OR (trig_en AND cap_valid AND cap_pc==trig_pc).
  - A match trigger writes its own sample.
  - force_trig without cap_valid writes nothing.
  - On trigger, remaining = min(post_cnt, DEPTH-1). If remaining==0, go -> READ; otherwise -> POST.
- POST: each cap_valid writes and decrements remaining. The write that brings remaining to 0 moves to READ. The clamp guarantees the trigger sample stays in the buffer.
- READ: rd_ptr starts at the oldest entry: wr_ptr if entries==DEPTH, else 0. Entries are output in capture order.
  - The handshake completes when rd_valid AND rd_ready. rd_ptr then advances.
  - rd_last is high with the entries-th output. Its handshake returns to IDLE.
  - If READ is entered with entries==0 (forced trigger, nothing captured), go straight to IDLE; rd_valid never asserts.
- cap_valid is ignored in IDLE and READ.
- arm is ignored outside IDLE.
- Simultaneous events:
  - abort beats arm, trigger and handshake.
  - A trigger and a cap_valid in the same cycle form one sample.
- rd_pc/rd_ir/rd_last stay stable while rd_valid is high and rd_ready is low.
- Buffer contents are not cleared by reset or abort. Only pointers and counts are cleared.

## Timing

- Reset values: rd_valid=0, rd_pc=0, rd_ir=0, rd_last=0, busy=0, done=0, entries=0, state=IDLE.
- rst mid-operation forces these values immediately. Capture or readout in progress is lost.
- Capture: a sample presented at edge N is in memory after edge N. entries and busy update at the same edge.
- Trigger: state changes on the edge that samples the trigger. busy drops and done rises on the edge of the final post-trigger write.
- Readout: memory read is registered. rd_valid rises 1 cycle after done rises.
- After an accepted handshake, the next entry is valid the following cycle. Sustained throughput is 1 entry per cycle with rd_ready held high.
- After the rd_last handshake, done and rd_valid are 0 on the next cycle.
- abort: takes effect at the next edge. rd_valid is 0 from that edge on.

## Test plan

All scenarios use DEPTH=8.

- **Wrap:** arm, trig_en=1, trig_pc=0x20, post_cnt=2. Feed cap_valid with PC 0x00,0x04,…,0x28 and IR=PC|0xA0000000.
  - Required: done after the 0x28 sample, entries=8.
  - Readout is 0x0C..0x28 in order, rd_last on 0x28.
- **No wrap:** trig_pc=0x08, post_cnt=1, PCs from 0x00.
  - Required: entries=4, readout 0x00,0x04,0x08,0x0C, rd_last on 0x0C.
- **Clamp:** post_cnt=15, trigger at PC 0x40, with 20 samples fed.
  - Required: capture stops 7 samples after the trigger.
  - The first readout entry is PC 0x40; 8 entries total.
- **Backpressure:** during readout, toggle rd_ready 1,0,0,1,…
  - Required: rd_pc/rd_ir are unchanged while rd_ready=0, with no skipped or duplicated entries.
- **Abort/force:**
  - abort in POST -> IDLE next cycle; busy=0, entries=0, rd_valid never asserts.
  - force_trig right after arm, with no cap_valid -> IDLE; rd_valid stays 0.
- **Async reset:** assert rst mid-readout, between clock edges.
  - Required: rd_valid, done and entries are 0 immediately.
  - After release, a new arm/capture works normally.

Source files
------------

// File: rtl/pipe_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_buffer
// Description : Instruction trace capture for the pipelined MIPS core.
//               Records (PC, IR) pairs from the fetch stage into a circular
//               buffer. Capture stops on a PC-match or forced trigger after a
//               programmable number of post-trigger samples. The captured
//               window is then streamed out oldest-first over a valid/ready
//               port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   arm               : pulse, IDLE -> ARMED (ignored elsewhere)
//   abort             : return to IDLE from any state, clears pointers/counts
//   trig_en, trig_pc  : PC-match trigger enable and compare value
//   force_trig        : immediate trigger while ARMED
//   post_cnt          : samples kept after the trigger sample (latched at trigger)
//   cap_valid/pc/ir   : fetch-stage sample
//   rd_valid/ready    : readout handshake
//   rd_pc/ir/last     : readout entry, last flag marks end of window
//   busy              : capturing (ARMED or POST)
//   done              : window ready for readout (READ)
//   entries           : valid entries held, saturates at DEPTH
// ============================================================================
module pipe_trace_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              abort,
    input  logic              trig_en,
    input  logic [ADDR_W-1:0] trig_pc,
    input  logic              force_trig,
    input  logic [CW-1:0]     post_cnt,
    input  logic              cap_valid,
    input  logic [ADDR_W-1:0] cap_pc,
    input  logic [DATA_W-1:0] cap_ir,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_ir,
    output logic              rd_last,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     entries
);

    localparam int            c_ptr_w    = $clog2(DEPTH);
    localparam int            c_word_w   = ADDR_W + DATA_W;
    localparam logic [CW-1:0] c_depth    = CW'(DEPTH);
    localparam logic [CW-1:0] c_post_max = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [c_ptr_w-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]        entries_q,   entries_d;
    logic [CW-1:0]        remaining_q, remaining_d;
    logic [CW-1:0]        rd_left_q,   rd_left_d;
    logic                 rd_valid_q,  rd_valid_d;
    logic [ADDR_W-1:0]    rd_pc_q,     rd_pc_d;
    logic [DATA_W-1:0]    rd_ir_q,     rd_ir_d;
    logic                 rd_last_q,   rd_last_d;

    // Trace storage; intentionally not reset so a window survives abort.
    logic [c_word_w-1:0]  mem_q [DEPTH];

    logic                 wr_en;
    logic                 trig_hit;
    logic [CW-1:0]        post_clamped;
    logic [CW-1:0]        entries_inc;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        entries_d    = entries_q;
        remaining_d  = remaining_q;
        rd_left_d    = rd_left_q;
        rd_valid_d   = rd_valid_q;
        rd_pc_d      = rd_pc_q;
        rd_ir_d      = rd_ir_q;
        rd_last_d    = rd_last_q;
        wr_en        = 1'b0;

        trig_hit     = force_trig | (trig_en & cap_valid & (cap_pc == trig_pc));
        // Capping post-trigger samples at DEPTH-1 keeps the trigger sample
        // from being overwritten before readout.
        post_clamped = (post_cnt > c_post_max) ? c_post_max : post_cnt;
        entries_inc  = (entries_q == c_depth) ? entries_q : entries_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d   = S_ARMED;
                    wr_ptr_d  = '0;
                    entries_d = '0;
                end
            end

            S_ARMED: begin
                // A match trigger and its sample are one and the same write.
                if (cap_valid) begin
                    wr_en     = 1'b1;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    entries_d = entries_inc;
                end
                if (trig_hit) begin
                    // Oldest entry: the slot about to be overwritten once the
                    // buffer has filled, otherwise slot 0.
                    rd_ptr_d  = (entries_d == c_depth) ? wr_ptr_d : '0;
                    rd_left_d = entries_d;
                    if (entries_d == '0) begin
                        // Forced trigger with nothing captured: no window.
                        state_d = S_IDLE;
                    end else if (post_clamped == '0) begin
                        state_d = S_READ;
                    end else begin
                        state_d     = S_POST;
                        remaining_d = post_clamped;
                    end
                end
            end

            S_POST: begin
                if (cap_valid) begin
                    wr_en       = 1'b1;
                    wr_ptr_d    = wr_ptr_q + 1'b1;
                    entries_d   = entries_inc;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == CW'(1)) begin
                        state_d   = S_READ;
                        rd_ptr_d  = (entries_d == c_depth) ? wr_ptr_d : '0;
                        rd_left_d = entries_d;
                    end
                end
            end

            S_READ: begin
                if (rd_valid_q && rd_ready && rd_last_q) begin
                    state_d    = S_IDLE;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end else if (!rd_valid_q || rd_ready) begin
                    // Output register is empty or being drained this cycle:
                    // refill it from the buffer for back-to-back streaming.
                    if (rd_left_q != '0) begin
                        rd_valid_d         = 1'b1;
                        {rd_pc_d, rd_ir_d} = mem_q[rd_ptr_q];
                        rd_last_d          = (rd_left_q == CW'(1));
                        rd_ptr_d           = rd_ptr_q + 1'b1;
                        rd_left_d          = rd_left_q - 1'b1;
                    end else begin
                        rd_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides every other event in the same cycle.
        if (abort) begin
            state_d     = S_IDLE;
            wr_en       = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            entries_d   = '0;
            remaining_d = '0;
            rd_left_d   = '0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            entries_q   <= '0;
            remaining_q <= '0;
            rd_left_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_pc_q     <= '0;
            rd_ir_q     <= '0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            entries_q   <= entries_d;
            remaining_q <= remaining_d;
            rd_left_q   <= rd_left_d;
            rd_valid_q  <= rd_valid_d;
            rd_pc_q     <= rd_pc_d;
            rd_ir_q     <= rd_ir_d;
            rd_last_q   <= rd_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {cap_pc, cap_ir};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_valid = rd_valid_q;
    assign rd_pc    = rd_pc_q;
    assign rd_ir    = rd_ir_q;
    assign rd_last  = rd_last_q;
    assign busy     = (state_q == S_ARMED) || (state_q == S_POST);
    assign done     = (state_q == S_READ);
    assign entries  = entries_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_trace_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_trace_buffer
// Description : Scoreboard bench for pipe_trace_buffer (DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_trace_buffer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CW     = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              arm, abort, trig_en, force_trig, cap_valid, rd_ready;
    logic [ADDR_W-1:0] trig_pc, cap_pc;
    logic [DATA_W-1:0] cap_ir;
    logic [CW-1:0]     post_cnt;
    logic              rd_valid, rd_last, busy, done;
    logic [ADDR_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_ir;
    logic [CW-1:0]     entries;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        last;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    pipe_trace_buffer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .trig_en(trig_en), .trig_pc(trig_pc), .force_trig(force_trig),
        .post_cnt(post_cnt), .cap_valid(cap_valid), .cap_pc(cap_pc),
        .cap_ir(cap_ir), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_pc(rd_pc), .rd_ir(rd_ir), .rd_last(rd_last), .busy(busy),
        .done(done), .entries(entries)
    );

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic push_window(input logic [31:0] first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc   = first + 32'(4 * i);
            e.ir   = e.pc | 32'hA000_0000;
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic feed(input logic [31:0] pc);
        @(negedge clk);
        cap_valid = 1'b1;
        cap_pc    = pc;
        cap_ir    = pc | 32'hA000_0000;
    endtask

    task automatic do_arm(input logic ten, input logic [31:0] tpc, input logic [CW-1:0] pc_n);
        @(negedge clk);
        arm = 1'b1; trig_en = ten; trig_pc = tpc; post_cnt = pc_n;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst = 1'b1;
        arm = 0; abort = 0; trig_en = 0; force_trig = 0; cap_valid = 0; rd_ready = 0;
        trig_pc = '0; cap_pc = '0; cap_ir = '0; post_cnt = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({rd_valid, rd_last, busy, done} !== 4'b0 || rd_pc !== '0 || rd_ir !== '0 || entries !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got valid=%b last=%b busy=%b done=%b pc=%h ir=%h entries=%0d expected all zero",
                     rd_valid, rd_last, busy, done, rd_pc, rd_ir, entries);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap;
        exp_t e;
        int cyc, first_cyc, last_cyc;
        do_arm(1'b1, 32'h20, 4'd2);
        vectors++;
        if (busy !== 1'b1 || entries !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_armed: got busy=%b entries=%0d expected busy=1 entries=0", busy, entries);
        end
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_early_done: got %b expected 0 before sample %0d", done, i);
            end
            cap_valid = 1'b1; cap_pc = 32'(4 * i); cap_ir = cap_pc | 32'hA000_0000;
        end
        @(negedge clk);
        cap_valid = 1'b0;
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || entries !== 4'd8 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_done: got done=%b busy=%b entries=%0d valid=%b expected 1 0 8 0",
                     done, busy, entries, rd_valid);
        end
        push_window(32'h0C, 8);
        cyc = 0; first_cyc = -1; last_cyc = -1;
        while (sb.size() != 0 && cyc < 64) begin
            rd_ready = 1'b1;
            if (rd_valid === 1'b1) begin
                e = sb.pop_front();
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                vectors++;
                if (rd_pc !== e.pc || rd_ir !== e.ir || rd_last !== e.last) begin
                    miscompares++;
                    $display("FAIL wrap_data: got pc=%h ir=%h last=%b expected pc=%h ir=%h last=%b",
                             rd_pc, rd_ir, rd_last, e.pc, e.ir, e.last);
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sb.size() != 0 || first_cyc != 1 || last_cyc - first_cyc != 7) begin
            miscompares++;
            $display("FAIL wrap_timing: got left=%0d first=%0d span=%0d expected left=0 first=1 span=7",
                     sb.size(), first_cyc, last_cyc - first_cyc);
        end
        vectors++;
        if (rd_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_end: got valid=%b done=%b expected 0 0", rd_valid, done);
        end
        rd_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_no_wrap;
        exp_t e;
        int cyc;
        do_arm(1'b1, 32'h08, 4'd1);
        feed(32'h00);
        feed(32'h04);
        arm = 1'b1;           // must be ignored while capturing
        feed(32'h08);
        arm = 1'b0;
        feed(32'h0C);
        @(negedge clk);
        cap_valid = 1'b0;
        vectors++;
        if (done !== 1'b1 || entries !== 4'd4) begin
            miscompares++;
            $display("FAIL nowrap_done: got done=%b entries=%0d expected 1 4", done, entries);
        end
        push_window(32'h00, 4);
        cyc = 0;
        while (sb.size() != 0 && cyc < 64) begin
            rd_ready = 1'b1;
            if (rd_valid === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (rd_pc !== e.pc || rd_ir !== e.ir || rd_last !== e.last) begin
                    miscompares++;
                    $display("FAIL nowrap_data: got pc=%h ir=%h last=%b expected pc=%h ir=%h last=%b",
                             rd_pc, rd_ir, rd_last, e.pc, e.ir, e.last);
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sb.size() != 0 || rd_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL nowrap_end: got left=%0d valid=%b done=%b expected 0 0 0", sb.size(), rd_valid, done);
        end
        rd_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_clamp;
        exp_t e;
        int cyc;
        do_arm(1'b1, 32'h40, 4'd15);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 15 || i == 16) begin
                vectors++;
                if (done !== (i == 16)) begin
                    miscompares++;
                    $display("FAIL clamp_stop: got done=%b expected %b at sample %0d", done, (i == 16), i);
                end
            end
            cap_valid = 1'b1; cap_pc = 32'h20 + 32'(4 * i); cap_ir = cap_pc | 32'hA000_0000;
        end
        @(negedge clk);
        cap_valid = 1'b0;
        vectors++;
        if (entries !== 4'd8 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL clamp_entries: got entries=%0d done=%b expected 8 1", entries, done);
        end
        push_window(32'h40, 8);
        cyc = 0;
        while (sb.size() != 0 && cyc < 64) begin
            rd_ready = 1'b1;
            if (rd_valid === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (rd_pc !== e.pc || rd_ir !== e.ir || rd_last !== e.last) begin
                    miscompares++;
                    $display("FAIL clamp_data: got pc=%h ir=%h last=%b expected pc=%h ir=%h last=%b",
                             rd_pc, rd_ir, rd_last, e.pc, e.ir, e.last);
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sb.size() != 0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_end: got left=%0d valid=%b expected 0 0", sb.size(), rd_valid);
        end
        rd_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_backpressure;
        exp_t e;
        int cyc;
        do_arm(1'b1, 32'h1010, 4'd3);
        for (int i = 0; i < 8; i++) feed(32'h1000 + 32'(4 * i));
        @(negedge clk);
        cap_valid = 1'b0;
        vectors++;
        if (entries !== 4'd8 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_entries: got entries=%0d done=%b expected 8 1", entries, done);
        end
        push_window(32'h1000, 8);
        cyc = 0;
        while (sb.size() != 0 && cyc < 96) begin
            rd_ready = (cyc % 3 == 0);
            if (rd_valid === 1'b1) begin
                e = rd_ready ? sb.pop_front() : sb[0];
                vectors++;
                if (rd_pc !== e.pc || rd_ir !== e.ir || rd_last !== e.last) begin
                    miscompares++;
                    $display("FAIL bp_data: got pc=%h ir=%h last=%b expected pc=%h ir=%h last=%b ready=%b",
                             rd_pc, rd_ir, rd_last, e.pc, e.ir, e.last, rd_ready);
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sb.size() != 0 || rd_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_end: got left=%0d valid=%b done=%b expected 0 0 0", sb.size(), rd_valid, done);
        end
        rd_ready = 1'b0;
        sb.delete();
    endtask

    task automatic test_abort;
        do_arm(1'b1, 32'h08, 4'd4);
        feed(32'h00); feed(32'h04); feed(32'h08); feed(32'h0C);
        @(negedge clk);
        cap_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || entries !== 4'd4) begin
            miscompares++;
            $display("FAIL abort_pre: got busy=%b entries=%0d expected 1 4", busy, entries);
        end
        abort = 1'b1; rd_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        vectors++;
        if (busy !== 1'b0 || entries !== 4'd0 || done !== 1'b0 || rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got busy=%b entries=%0d done=%b valid=%b expected 0 0 0 0",
                     busy, entries, done, rd_valid);
        end
        for (int i = 0; i < 5; i++) begin
            feed(32'h100 + 32'(4 * i));   // ignored in IDLE
            vectors++;
            if (rd_valid !== 1'b0 || entries !== 4'd0) begin
                miscompares++;
                $display("FAIL abort_quiet: got valid=%b entries=%0d expected 0 0", rd_valid, entries);
            end
        end
        @(negedge clk);
        cap_valid = 1'b0; rd_ready = 1'b0;
    endtask

    task automatic test_force;
        @(negedge clk);
        arm = 1'b1; trig_en = 1'b0; post_cnt = 4'd3;
        @(negedge clk);
        arm = 1'b0; force_trig = 1'b1; rd_ready = 1'b1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL force_armed: got busy=%b expected 1", busy);
        end
        @(negedge clk);
        force_trig = 1'b0;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || entries !== 4'd0) begin
            miscompares++;
            $display("FAIL force_idle: got busy=%b done=%b entries=%0d expected 0 0 0", busy, done, entries);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (rd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL force_quiet: got valid=%b expected 0", rd_valid);
            end
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        exp_t e;
        int cyc;
        do_arm(1'b1, 32'h08, 4'd1);
        feed(32'h00); feed(32'h04); feed(32'h08); feed(32'h0C);
        @(negedge clk);
        cap_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1 || rd_pc !== 32'h00) begin
            miscompares++;
            $display("FAIL rst_pre: got valid=%b pc=%h expected 1 00000000", rd_valid, rd_pc);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (rd_valid !== 1'b0 || done !== 1'b0 || entries !== 4'd0 || busy !== 1'b0 ||
            rd_pc !== '0 || rd_last !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: got valid=%b done=%b entries=%0d busy=%b pc=%h last=%b expected all zero",
                     rd_valid, done, entries, busy, rd_pc, rd_last);
        end
        @(negedge clk);
        rst = 1'b0;
        // Post-reset capture: forced trigger coinciding with a sample, no post samples.
        do_arm(1'b0, 32'h0, 4'd0);
        feed(32'h300);
        feed(32'h304);
        feed(32'h308);
        force_trig = 1'b1;
        @(negedge clk);
        cap_valid = 1'b0; force_trig = 1'b0;
        vectors++;
        if (done !== 1'b1 || entries !== 4'd3) begin
            miscompares++;
            $display("FAIL rst_recap: got done=%b entries=%0d expected 1 3", done, entries);
        end
        push_window(32'h300, 3);
        cyc = 0;
        while (sb.size() != 0 && cyc < 64) begin
            rd_ready = 1'b1;
            if (rd_valid === 1'b1) begin
                e = sb.pop_front();
                vectors++;
                if (rd_pc !== e.pc || rd_ir !== e.ir || rd_last !== e.last) begin
                    miscompares++;
                    $display("FAIL rst_data: got pc=%h ir=%h last=%b expected pc=%h ir=%h last=%b",
                             rd_pc, rd_ir, rd_last, e.pc, e.ir, e.last);
                end
            end
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (sb.size() != 0 || rd_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_end: got left=%0d valid=%b done=%b expected 0 0 0", sb.size(), rd_valid, done);
        end
        rd_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_no_wrap();
        test_clamp();
        test_backpressure();
        test_abort();
        test_force();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
